// File: rtl/tick_generator_if.sv
// Control and strobe bundle of the timebase: run/divisor controls in, clock-enable strobes out.
interface tick_generator_if #(
  parameter int PROG_WIDTH = 16,
  parameter int ROLL_WIDTH = 8
);
  logic                  ENABLE;
  logic [PROG_WIDTH-1:0] PROG_DIV;
  logic                  PROG_LOAD;
  logic                  PIX_TICK;
  logic                  US_TICK;
  logic                  MS_TICK;
  logic                  S_TICK;
  logic                  PROG_TICK;
  logic [ROLL_WIDTH-1:0] ROLL_COUNT;
  logic                  ROLL_WRAP;

  modport master (
    output ENABLE, PROG_DIV, PROG_LOAD,
    input  PIX_TICK, US_TICK, MS_TICK, S_TICK, PROG_TICK, ROLL_COUNT, ROLL_WRAP
  );

  modport slave (
    input  ENABLE, PROG_DIV, PROG_LOAD,
    output PIX_TICK, US_TICK, MS_TICK, S_TICK, PROG_TICK, ROLL_COUNT, ROLL_WRAP
  );
endinterface

// File: rtl/tick_generator.sv
// Single-clock timebase: cascaded pixel/us/ms/s clock-enable strobes, a run-time
// programmable divider channel and a roll counter of seconds with a wrap strobe.
module tick_generator #(
  parameter int DIV_PIX      = 4,
  parameter int DIV_US       = 100,
  parameter int DIV_MS       = 1000,
  parameter int DIV_S        = 1000,
  parameter int PROG_WIDTH   = 16,
  parameter int PROG_DEFAULT = 25,
  parameter int ROLL_WIDTH   = 8
) (
  input  logic CLK,
  input  logic RESET,
  tick_generator_if.slave bus
);
  localparam int PIX_W = $clog2(DIV_PIX);
  localparam int US_W  = $clog2(DIV_US);
  localparam int MS_W  = $clog2(DIV_MS);
  localparam int S_W   = $clog2(DIV_S);

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(DIV_PIX - 1);
  localparam logic [US_W-1:0]  US_LAST  = US_W'(DIV_US - 1);
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(DIV_MS - 1);
  localparam logic [S_W-1:0]   S_LAST   = S_W'(DIV_S - 1);

  logic [PIX_W-1:0]      pix_cnt_reg, pix_cnt_next;
  logic [US_W-1:0]       us_cnt_reg, us_cnt_next;
  logic [MS_W-1:0]       ms_cnt_reg, ms_cnt_next;
  logic [S_W-1:0]        s_cnt_reg, s_cnt_next;
  logic [PROG_WIDTH-1:0] prog_div_reg, prog_div_next;
  logic [PROG_WIDTH-1:0] prog_cnt_reg, prog_cnt_next;
  logic [ROLL_WIDTH-1:0] roll_count_reg, roll_count_next;

  logic pix_tick, us_tick, ms_tick, s_tick, prog_tick, roll_wrap;

  // Strobes are pure decodes of the registered state, so they carry no latency.
  always_comb begin
    pix_tick  = bus.ENABLE && (pix_cnt_reg == PIX_LAST);
    us_tick   = bus.ENABLE && (us_cnt_reg == US_LAST);
    ms_tick   = us_tick && (ms_cnt_reg == MS_LAST);
    s_tick    = ms_tick && (s_cnt_reg == S_LAST);
    prog_tick = bus.ENABLE && !bus.PROG_LOAD && (prog_div_reg != '0)
                && (prog_cnt_reg == prog_div_reg - PROG_WIDTH'(1));
    roll_wrap = s_tick && (&roll_count_reg);
  end

  always_comb begin
    pix_cnt_next    = pix_cnt_reg;
    us_cnt_next     = us_cnt_reg;
    ms_cnt_next     = ms_cnt_reg;
    s_cnt_next      = s_cnt_reg;
    prog_div_next   = prog_div_reg;
    prog_cnt_next   = prog_cnt_reg;
    roll_count_next = roll_count_reg;

    if (bus.ENABLE) begin
      pix_cnt_next = pix_tick ? '0 : pix_cnt_reg + PIX_W'(1);
      us_cnt_next  = us_tick ? '0 : us_cnt_reg + US_W'(1);
    end
    if (us_tick) begin
      ms_cnt_next = ms_tick ? '0 : ms_cnt_reg + MS_W'(1);
    end
    if (ms_tick) begin
      s_cnt_next = s_tick ? '0 : s_cnt_reg + S_W'(1);
    end
    if (s_tick) begin
      roll_count_next = roll_count_reg + ROLL_WIDTH'(1);
    end

    // A load acts even while frozen; a zero divisor parks the counter at 0.
    if (bus.PROG_LOAD) begin
      prog_div_next = bus.PROG_DIV;
      prog_cnt_next = '0;
    end else if (bus.ENABLE && (prog_div_reg != '0)) begin
      prog_cnt_next = prog_tick ? '0 : prog_cnt_reg + PROG_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pix_cnt_reg    <= '0;
      us_cnt_reg     <= '0;
      ms_cnt_reg     <= '0;
      s_cnt_reg      <= '0;
      prog_div_reg   <= PROG_WIDTH'(PROG_DEFAULT);
      prog_cnt_reg   <= '0;
      roll_count_reg <= '0;
    end else begin
      pix_cnt_reg    <= pix_cnt_next;
      us_cnt_reg     <= us_cnt_next;
      ms_cnt_reg     <= ms_cnt_next;
      s_cnt_reg      <= s_cnt_next;
      prog_div_reg   <= prog_div_next;
      prog_cnt_reg   <= prog_cnt_next;
      roll_count_reg <= roll_count_next;
    end
  end

  assign bus.PIX_TICK   = pix_tick;
  assign bus.US_TICK    = us_tick;
  assign bus.MS_TICK    = ms_tick;
  assign bus.S_TICK     = s_tick;
  assign bus.PROG_TICK  = prog_tick;
  assign bus.ROLL_COUNT = roll_count_reg;
  assign bus.ROLL_WRAP  = roll_wrap;
endmodule

// File: tb/tb_tick_generator.sv
// Self-checking bench for tick_generator: fixed timing tables, corner-case sequences
// and a randomized run against an arithmetic reference model.
module tb_tick_generator;
  localparam int DIV_PIX      = 4;
  localparam int DIV_US       = 5;
  localparam int DIV_MS       = 3;
  localparam int DIV_S        = 2;
  localparam int PROG_WIDTH   = 16;
  localparam int PROG_DEFAULT = 25;
  localparam int ROLL_WIDTH   = 2;
  localparam int MS_PERIOD    = DIV_US * DIV_MS;
  localparam int S_PERIOD     = MS_PERIOD * DIV_S;
  localparam int ROLL_MOD     = 1 << ROLL_WIDTH;

  // signal indices into the history table
  localparam int SIG_PIX = 0, SIG_US = 1, SIG_MS = 2, SIG_S = 3, SIG_PROG = 4, SIG_ROLL = 5, SIG_WRAP = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tick_generator_if #(.PROG_WIDTH(PROG_WIDTH), .ROLL_WIDTH(ROLL_WIDTH)) bus ();

  tick_generator #(
    .DIV_PIX(DIV_PIX), .DIV_US(DIV_US), .DIV_MS(DIV_MS), .DIV_S(DIV_S),
    .PROG_WIDTH(PROG_WIDTH), .PROG_DEFAULT(PROG_DEFAULT), .ROLL_WIDTH(ROLL_WIDTH)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: e = enabled cycles since reset, p = enabled non-load cycles since the last load.
  int e = 0, p = 0, pdiv = PROG_DEFAULT, cyc = 0;
  int hist[7][0:127];

  typedef struct {
    string name;
    int    sig;
    int    c;
    int    exp;
  } point_t;

  typedef struct {
    bit ld;
    int dv;
    bit exp_prog;
  } pvec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {bus.PIX_TICK, bus.US_TICK, bus.MS_TICK, bus.S_TICK, bus.PROG_TICK, bus.ROLL_COUNT, bus.ROLL_WRAP};
  endfunction

  // One clock cycle: drive inputs, compare against the model, then advance the model past the edge.
  task automatic apply(input bit r, input bit en, input bit ld, input int dv, input bit chk);
    logic [7:0] exp_v;
    bit m_pix, m_us, m_ms, m_s, m_prog, m_wrap;
    int m_roll, cur;
    @(negedge clk);
    rst           = r;
    bus.ENABLE    = en;
    bus.PROG_LOAD = ld;
    bus.PROG_DIV  = dv[PROG_WIDTH-1:0];
    #1;
    cur    = cyc;
    m_pix  = en && (e % DIV_PIX == DIV_PIX - 1);
    m_us   = en && (e % DIV_US == DIV_US - 1);
    m_ms   = en && (e % MS_PERIOD == MS_PERIOD - 1);
    m_s    = en && (e % S_PERIOD == S_PERIOD - 1);
    m_roll = (e / S_PERIOD) % ROLL_MOD;
    m_wrap = m_s && (m_roll == ROLL_MOD - 1);
    m_prog = en && !ld && (pdiv != 0) && (p % pdiv == pdiv - 1);
    exp_v  = {m_pix, m_us, m_ms, m_s, m_prog, m_roll[ROLL_WIDTH-1:0], m_wrap};
    if (chk) check($sformatf("model c%0d", cur), 32'(outs()), 32'(exp_v));
    if (cur >= 0 && cur < 128) begin
      hist[SIG_PIX][cur]  = int'(bus.PIX_TICK);
      hist[SIG_US][cur]   = int'(bus.US_TICK);
      hist[SIG_MS][cur]   = int'(bus.MS_TICK);
      hist[SIG_S][cur]    = int'(bus.S_TICK);
      hist[SIG_PROG][cur] = int'(bus.PROG_TICK);
      hist[SIG_ROLL][cur] = int'(bus.ROLL_COUNT);
      hist[SIG_WRAP][cur] = int'(bus.ROLL_WRAP);
    end
    if (r) begin
      e = 0; p = 0; pdiv = PROG_DEFAULT; cyc = 0;
    end else begin
      if (ld) begin
        pdiv = dv; p = 0;
      end else if (en) begin
        p++;
      end
      if (en) e++;
      cyc++;
    end
  endtask

  task automatic do_reset(input bit chk_first);
    apply(1'b1, 1'b1, 1'b0, 0, chk_first);
    apply(1'b1, 1'b1, 1'b0, 0, 1'b1);
    check("reset outputs", 32'(outs()), 32'(0));
  endtask

  task automatic check_points(input point_t pts[$]);
    foreach (pts[i]) begin
      check($sformatf("%s@%0d", pts[i].name, pts[i].c), 32'(hist[pts[i].sig][pts[i].c]), 32'(pts[i].exp));
      $display("point %s cycle %0d: got %0d want %0d", pts[i].name, pts[i].c, hist[pts[i].sig][pts[i].c], pts[i].exp);
    end
  endtask

  initial begin
    point_t pts[$];
    pvec_t  pv[$];

    bus.ENABLE = 1'b1; bus.PROG_LOAD = 1'b0; bus.PROG_DIV = '0;

    // Free run, roll wrap and default divisor
    do_reset(1'b0);
    for (int c = 0; c < 125; c++) apply(1'b0, 1'b1, 1'b0, 0, 1'b1);
    pts = '{
      '{"pix", SIG_PIX, 3, 1}, '{"pix", SIG_PIX, 7, 1}, '{"pix", SIG_PIX, 11, 1}, '{"pix", SIG_PIX, 4, 0},
      '{"us", SIG_US, 4, 1}, '{"us", SIG_US, 9, 1}, '{"us", SIG_US, 14, 1}, '{"us", SIG_US, 5, 0},
      '{"ms", SIG_MS, 14, 1}, '{"ms", SIG_MS, 29, 1}, '{"ms", SIG_MS, 9, 0},
      '{"s", SIG_S, 29, 1}, '{"s", SIG_S, 59, 1}, '{"s", SIG_S, 119, 1}, '{"s", SIG_S, 14, 0}, '{"s", SIG_S, 30, 0},
      '{"roll", SIG_ROLL, 29, 0}, '{"roll", SIG_ROLL, 30, 1}, '{"roll", SIG_ROLL, 60, 2},
      '{"roll", SIG_ROLL, 90, 3}, '{"roll", SIG_ROLL, 119, 3}, '{"roll", SIG_ROLL, 120, 0},
      '{"wrap", SIG_WRAP, 119, 1}, '{"wrap", SIG_WRAP, 89, 0}, '{"wrap", SIG_WRAP, 120, 0},
      '{"prog", SIG_PROG, 24, 1}, '{"prog", SIG_PROG, 49, 1}, '{"prog", SIG_PROG, 74, 1}, '{"prog", SIG_PROG, 25, 0}
    };
    check_points(pts);

    // Programmable load sequence: 3, then 1, then 0
    do_reset(1'b1);
    for (int c = 0; c < 10; c++) pv.push_back('{1'b0, 0, 1'b0});
    pv.push_back('{1'b1, 3, 1'b0});
    for (int c = 11; c < 20; c++) pv.push_back('{1'b0, 0, bit'((c - 13) % 3 == 0 && c >= 13)});
    pv.push_back('{1'b1, 1, 1'b0});
    for (int c = 21; c < 27; c++) pv.push_back('{1'b0, 0, 1'b1});
    pv.push_back('{1'b1, 0, 1'b0});
    for (int c = 28; c < 38; c++) pv.push_back('{1'b0, 0, 1'b0});
    foreach (pv[i]) begin
      apply(1'b0, 1'b1, pv[i].ld, pv[i].dv, 1'b1);
      check($sformatf("prog vec %0d", i), 32'(bus.PROG_TICK), 32'(pv[i].exp_prog));
      $display("prog vec %0d: load=%0d div=%0d tick=%0d want %0d", i, pv[i].ld, pv[i].dv, bus.PROG_TICK, pv[i].exp_prog);
    end

    // ENABLE freeze for cycles 6..15
    do_reset(1'b1);
    for (int c = 0; c < 21; c++) begin
      apply(1'b0, !(c >= 6 && c < 16), 1'b0, 0, 1'b1);
      if (c >= 6 && c < 16) check($sformatf("freeze ticks c%0d", c),
          32'({bus.PIX_TICK, bus.US_TICK, bus.MS_TICK, bus.S_TICK, bus.PROG_TICK, bus.ROLL_WRAP}), 32'(0));
    end
    pts = '{
      '{"frz pix", SIG_PIX, 16, 0}, '{"frz pix", SIG_PIX, 17, 1},
      '{"frz us", SIG_US, 18, 0}, '{"frz us", SIG_US, 19, 1}
    };
    check_points(pts);

    // Reset mid-operation together with a load
    do_reset(1'b1);
    for (int c = 0; c < 40; c++) apply(1'b0, 1'b1, 1'b0, 0, 1'b1);
    apply(1'b1, 1'b1, 1'b1, 7, 1'b1);
    for (int c = 0; c < 31; c++) apply(1'b0, 1'b1, 1'b0, 0, 1'b1);
    pts = '{
      '{"rst pix", SIG_PIX, 0, 0}, '{"rst pix", SIG_PIX, 3, 1}, '{"rst us", SIG_US, 4, 1},
      '{"rst ms", SIG_MS, 14, 1}, '{"rst s", SIG_S, 29, 1}, '{"rst prog", SIG_PROG, 24, 1},
      '{"rst prog", SIG_PROG, 6, 0}, '{"rst roll", SIG_ROLL, 30, 1}
    };
    check_points(pts);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      bit r, en, ld;
      int dv;
      r  = ($urandom % 200) == 0;
      en = ($urandom % 8) != 0;
      ld = ($urandom % 25) == 0;
      dv = int'($urandom_range(0, 9));
      apply(r, en, ld, dv, 1'b1);
      if (ld) $display("random load: cycle %0d div=%0d enable=%0d reset=%0d", i, dv, en, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
